// File: rtl/rv32f_pkg.sv
// rv32f_pkg: shared constants for the RV32F register file and fcsr.
//   CSR addresses, CSR op encodings, fflags bit positions, rounding modes.
package rv32f_pkg;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;
    localparam int FRM_LSB = 5;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

endpackage

// File: rtl/rv32f_fcsr.sv
// rv32f_fcsr: fcsr state (frm + fflags), Zicsr read/write/set/clear and flag accrual.
//   iCLK/iRST_N      clock, async active-low reset
//   iCSR_EN/OP/ADDR  CSR access control; iCSR_WDATA operand
//   iFLAGS_VALID     OR iFLAGS {NV,DZ,OF,UF,NX} into fflags after any CSR update
//   oCSR_RDATA       pre-update value of the addressed CSR, zero-extended
//   oFRM             registered dynamic rounding mode
module rv32f_fcsr (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iCSR_EN,
    input  logic [1:0]  iCSR_OP,
    input  logic [11:0] iCSR_ADDR,
    input  logic [31:0] iCSR_WDATA,
    input  logic        iFLAGS_VALID,
    input  logic [4:0]  iFLAGS,
    output logic [31:0] oCSR_RDATA,
    output logic [2:0]  oFRM
);
    import rv32f_pkg::*;

    logic [7:0] r_fcsr;
    logic [7:0] w_mask;
    logic [7:0] w_wd;
    logic [7:0] w_csr_next;
    logic       w_unused;

    assign w_unused = &{1'b0, iCSR_WDATA[31:8]};

    // Field mask and operand aligned to fcsr bit positions; unknown address gives an empty mask, so no change.
    always_comb begin
        w_mask = iCSR_ADDR == CSR_FFLAGS ? 8'h1F :
                 iCSR_ADDR == CSR_FRM    ? 8'hE0 :
                 iCSR_ADDR == CSR_FCSR   ? 8'hFF : 8'h00;
        w_wd = (iCSR_ADDR == CSR_FRM ? {iCSR_WDATA[2:0], 5'b0} : iCSR_WDATA[7:0]) & w_mask;
        w_csr_next = !iCSR_EN                  ? r_fcsr :
                     iCSR_OP == CSR_OP_WRITE   ? (r_fcsr & ~w_mask) | w_wd :
                     iCSR_OP == CSR_OP_SET     ? r_fcsr | w_wd :
                     iCSR_OP == CSR_OP_CLEAR   ? r_fcsr & ~w_wd : r_fcsr;
        oCSR_RDATA = !iCSR_EN                 ? 32'h0 :
                     iCSR_ADDR == CSR_FFLAGS  ? {27'h0, r_fcsr[FRM_LSB-1:0]} :
                     iCSR_ADDR == CSR_FRM     ? {29'h0, r_fcsr[7:FRM_LSB]} :
                     iCSR_ADDR == CSR_FCSR    ? {24'h0, r_fcsr} : 32'h0;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            r_fcsr <= 8'h0;
        else
            r_fcsr <= {w_csr_next[7:FRM_LSB], w_csr_next[FRM_LSB-1:0] | (iFLAGS_VALID ? iFLAGS : 5'h0)};
    end

    assign oFRM = r_fcsr[7:FRM_LSB];

endmodule

// File: rtl/rv32f_regfile.sv
// rv32f_regfile: f0-f31 FP register file with load-use/WAW scoreboard and fcsr.
//   iRS1..3/iRS_USE       read addresses and which ones are really read
//   oRS1..3_DATA          combinational read data
//   iWE/iWR_RD/iWR_DATA   write-back port; clears the destination busy bit
//   iISSUE_*              FP-destination issue; long ops set the busy bit
//   oSTALL                RAW on a busy source or WAW on a busy destination
//   iFLAGS_*, iCSR_*      flag accrual and Zicsr access, handled by rv32f_fcsr
//   oCSR_RDATA, oFRM      CSR read data and rounding mode
// Macro RV32F_FRF_BYPASS_EN: forward write-back data to matching read ports in the same cycle.
module rv32f_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic [4:0]      iRS1,
    input  logic [4:0]      iRS2,
    input  logic [4:0]      iRS3,
    input  logic [2:0]      iRS_USE,
    output logic [XLEN-1:0] oRS1_DATA,
    output logic [XLEN-1:0] oRS2_DATA,
    output logic [XLEN-1:0] oRS3_DATA,
    input  logic            iWE,
    input  logic [4:0]      iWR_RD,
    input  logic [XLEN-1:0] iWR_DATA,
    input  logic            iISSUE_VALID,
    input  logic [4:0]      iISSUE_RD,
    input  logic            iISSUE_LONG,
    output logic            oSTALL,
    input  logic            iFLAGS_VALID,
    input  logic [4:0]      iFLAGS,
    input  logic            iCSR_EN,
    input  logic [1:0]      iCSR_OP,
    input  logic [11:0]     iCSR_ADDR,
    input  logic [31:0]     iCSR_WDATA,
    output logic [31:0]     oCSR_RDATA,
    output logic [2:0]      oFRM
);
    import rv32f_pkg::*;

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [4:0]      w_rs   [3];
    logic [XLEN-1:0] w_rd   [3];
    logic [2:0]      w_byp;
    logic [2:0]      w_raw;

    assign w_rs[0] = iRS1;
    assign w_rs[1] = iRS2;
    assign w_rs[2] = iRS3;

    for (genvar k = 0; k < 3; k++) begin : g_rd
`ifdef RV32F_FRF_BYPASS_EN
        assign w_byp[k] = iWE && iWR_RD == w_rs[k];
`else
        assign w_byp[k] = 1'b0;
`endif
        assign w_rd[k]  = w_byp[k] ? iWR_DATA : r_regs[w_rs[k]];
        // A forwarded port already has its data, so its busy bit no longer matters.
        assign w_raw[k] = iRS_USE[k] && r_busy[w_rs[k]] && !w_byp[k];
    end

    assign oRS1_DATA = w_rd[0];
    assign oRS2_DATA = w_rd[1];
    assign oRS3_DATA = w_rd[2];

    assign oSTALL = |w_raw || (iISSUE_VALID && r_busy[iISSUE_RD]);
    assign w_set  = (iISSUE_VALID && iISSUE_LONG && !oSTALL) ? NREG'(1) << iISSUE_RD : '0;
    assign w_clr  = iWE ? NREG'(1) << iWR_RD : '0;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_busy <= '0;
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            // Set after clear: a new long issue to the same index keeps it busy.
            r_busy <= (r_busy & ~w_clr) | w_set;
            if (iWE)
                r_regs[iWR_RD] <= iWR_DATA;
        end
    end

    rv32f_fcsr u_fcsr (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .iCSR_EN      (iCSR_EN),
        .iCSR_OP      (iCSR_OP),
        .iCSR_ADDR    (iCSR_ADDR),
        .iCSR_WDATA   (iCSR_WDATA),
        .iFLAGS_VALID (iFLAGS_VALID),
        .iFLAGS       (iFLAGS),
        .oCSR_RDATA   (oCSR_RDATA),
        .oFRM         (oFRM)
    );

endmodule
